// File: rtl/cdb_arbiter_pkg.sv
// Shared types and defaults for the CDB arbiter slice.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_SRC   = 8;
  localparam int CDB_TAG_W     = 3;
  localparam int CDB_DATA_W    = 32;
  localparam int CDB_BUF_DEPTH = 2;

  // One completed result waiting for the common data bus.
  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_entry_t;

  // (a + b) mod m. Used for the round-robin scan with a constant modulus.
  function automatic int wrap_add(int a, int b, int m);
    return (a + b) % m;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-source and broadcast bus bundle.
// The master modport is the arbiter: it drives src_ready and the broadcast word.
// The slave modport is the environment: functional units plus the bus consumers.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = CDB_NUM_SRC,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);

  logic [NUM_SRC-1:0]             src_valid;
  logic [NUM_SRC-1:0][TAG_W-1:0]  src_tag;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]             src_ready;

  logic                           cdb_valid;
  logic [TAG_W-1:0]               cdb_tag;
  logic [DATA_W-1:0]              cdb_data;
  logic [SRC_W-1:0]               cdb_src;

  modport master (
    input  src_valid, src_tag, src_data,
    output src_ready,
    output cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    output src_valid, src_tag, src_data,
    input  src_ready,
    input  cdb_valid, cdb_tag, cdb_data, cdb_src
  );

endinterface

// File: rtl/cdb_arbiter_src_fifo.sv
// Per-source circular result buffer. Flush and reset both empty it.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int  DEPTH   = CDB_BUF_DEPTH,
  parameter type entry_t = cdb_entry_t,
  parameter int  CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  entry_t           din_i,
  input  logic             pop_i,
  output entry_t           dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Next pointers and occupancy; push and pop in one cycle leave count unchanged.
  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Pointer/count state; reset and flush both drop everything buffered.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that buffers functional-unit results per source and
// drives one registered common-data-bus word per cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = CDB_NUM_SRC,
  parameter int TAG_W     = CDB_TAG_W,
  parameter int DATA_W    = CDB_DATA_W,
  parameter int BUF_DEPTH = CDB_BUF_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.master bus
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             fifo_head  [NUM_SRC];
  logic [CNT_W-1:0]   fifo_count [NUM_SRC];
  logic [NUM_SRC-1:0] fifo_full;
  logic [NUM_SRC-1:0] fifo_empty;
  logic [NUM_SRC-1:0] src_ready;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] req;

  logic               grant_valid;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   cand;

  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      // Ready looks at occupancy only, so a source never waits on the grant.
      assign src_ready[gi] = (fifo_count[gi] < CNT_W'(BUF_DEPTH)) & ~rst & ~flush;
      // The full guard keeps the buffer safe regardless of how ready is formed.
      assign push[gi]      = bus.src_valid[gi] & src_ready[gi] & ~fifo_full[gi];
      assign pop[gi]       = grant_valid & (grant_idx == SRC_W'(gi)) & ~flush;
      assign req[gi]       = ~fifo_empty[gi];

      cdb_src_fifo #(
        .DEPTH   (BUF_DEPTH),
        .entry_t (entry_t),
        .CNT_W   (CNT_W)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push[gi]),
        .din_i   ({bus.src_tag[gi], bus.src_data[gi]}),
        .pop_i   (pop[gi]),
        .dout_o  (fifo_head[gi]),
        .full_o  (fifo_full[gi]),
        .empty_o (fifo_empty[gi]),
        .count_o (fifo_count[gi])
      );
    end
  endgenerate

  // Pick the first non-empty source at or after rr_ptr, wrapping upward.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = SRC_W'(wrap_add(int'(rr_ptr_q), k, NUM_SRC));
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next broadcast word and pointer; tag/data/src hold when nothing is granted.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = grant_valid;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (grant_valid) begin
      cdb_tag_d  = fifo_head[grant_idx].tag;
      cdb_data_d = fifo_head[grant_idx].data;
      cdb_src_d  = grant_idx;
      rr_ptr_d   = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Output register and pointer; reset beats flush, flush kills the broadcast.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else if (flush) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign bus.src_ready = src_ready;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed stimulus queues expected
// broadcasts (including the cycle they must appear in); a negedge monitor
// pops and compares every valid broadcast word.
module tb_cdb_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   check_cnt = 0;

  typedef struct {
    logic [2:0]  tag;
    logic [31:0] data;
    logic [2:0]  src;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  cdb_arbiter_if #(.NUM_SRC(8), .TAG_W(3), .DATA_W(32), .SRC_W(3)) bus ();

  cdb_arbiter #(.NUM_SRC(8), .TAG_W(3), .DATA_W(32), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h (cyc %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [31:0] mk(int t, int s, int n);
    return (32'(t) << 28) | (32'(s) << 8) | 32'(n);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int s, logic [2:0] tag, logic [31:0] data);
    bus.src_valid[s] = 1'b1;
    bus.src_tag[s]   = tag;
    bus.src_data[s]  = data;
  endtask

  task automatic clear_all();
    bus.src_valid = '0;
  endtask

  task automatic expect_txn(int s, logic [2:0] tag, logic [31:0] data, int c);
    exp_t e;
    e.tag = tag; e.data = data; e.src = 3'(s); e.cyc = c;
    sb.push_back(e);
  endtask

  // Monitor: every valid broadcast must match the oldest expectation, cycle included.
  always @(negedge clk) begin
    if (bus.cdb_valid) begin
      if (sb.size() == 0) begin
        check_cnt++;
        $display("FAIL unexpected_bcast actual src=%0d tag=%0d data=%h cyc=%0d required no broadcast",
                 bus.cdb_src, bus.cdb_tag, bus.cdb_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("bcast", {bus.cdb_tag, bus.cdb_data, bus.cdb_src, 32'(cyc)},
                     {mon_e.tag, mon_e.data, mon_e.src, 32'(mon_e.cyc)});
        $display("txn src=%0d tag=%0d data=%h cyc=%0d", bus.cdb_src, bus.cdb_tag, bus.cdb_data, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, p, acc, n1, n6;
    logic a1, a6;
    rst = 1'b1; flush = 1'b0;
    bus.src_valid = '0; bus.src_tag = '0; bus.src_data = '0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("rst_valid", bus.cdb_valid, 0);
    chk("rst_tag", bus.cdb_tag, 0);
    chk("rst_data", bus.cdb_data, 0);
    chk("rst_src", bus.cdb_src, 0);
    chk("rst_ready", bus.src_ready, 8'h00);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.src_ready, 8'hFF);

    // 1: single source, one-cycle-after-acceptance latency
    step();
    d = cyc;
    expect_txn(2, 3'd5, 32'hDEAD_BEEF, d + 2);
    drive(2, 3'd5, 32'hDEAD_BEEF);
    step(); clear_all();
    repeat (3) step();

    // 2: all sources at once from rr_ptr=0 (flush first to rewind the pointer)
    flush = 1'b1;
    step();
    flush = 1'b0;
    d = cyc;
    for (int k = 0; k < 8; k++) begin
      expect_txn(k, 3'(k), mk(2, k, 0), d + 2 + k);
      drive(k, 3'(k), mk(2, k, 0));
    end
    step(); clear_all();
    repeat (9) step();
    @(negedge clk);
    chk("all8_idle_after", bus.cdb_valid, 0);
    step();

    // 3: backpressure on source 3 behind sources 0..2
    d = cyc;
    for (int s = 0; s < 4; s++) expect_txn(s, 3'(s), mk(3, s, 0), d + 2 + s);
    for (int s = 0; s < 4; s++) expect_txn(s, 3'(s + 1), mk(3, s, 1), d + 6 + s);
    expect_txn(3, 3'd5, mk(3, 3, 2), d + 10);
    for (int s = 0; s < 4; s++) drive(s, 3'(s), mk(3, s, 0));
    step();
    for (int s = 0; s < 4; s++) drive(s, 3'(s + 1), mk(3, s, 1));
    step();
    clear_all();
    drive(3, 3'd5, mk(3, 3, 2));
    @(negedge clk);
    chk("bp_ready3_full", bus.src_ready[3], 0);
    chk("bp_ready1_full", bus.src_ready[1], 0);
    chk("bp_ready0_free", bus.src_ready[0], 1);
    step();
    acc = -1;
    for (int i = 0; i < 10 && acc < 0; i++) begin
      @(negedge clk);
      if (bus.src_ready[3]) acc = cyc;
      step();
    end
    clear_all();
    chk("bp_accept_cyc", 96'(acc), 96'(d + 5));
    repeat (6) step();

    // 4: fairness, sources 1 and 6 always valid; rr_ptr starts at 4 so 6 goes first
    d = cyc;
    for (int j = 0; j < 5; j++) begin
      expect_txn(6, 3'(j), mk(4, 6, j), d + 2 + 2 * j);
      expect_txn(1, 3'(j), mk(4, 1, j), d + 3 + 2 * j);
    end
    n1 = 0; n6 = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1, 3'(n1), mk(4, 1, n1));
      drive(6, 3'(n6), mk(4, 6, n6));
      a1 = bus.src_ready[1];
      a6 = bus.src_ready[6];
      step();
      if (a1) n1++;
      if (a6) n6++;
    end
    clear_all();
    chk("fair_acc1", 96'(n1), 96'(5));
    chk("fair_acc6", 96'(n6), 96'(5));
    repeat (5) step();

    // 5: flush with 4 buffered entries, then pointer back at 0
    for (int s = 0; s < 8; s++) if (s == 0 || s == 1 || s == 4 || s == 5) drive(s, 3'(s), mk(5, s, 0));
    step();
    clear_all();
    flush = 1'b1;
    drive(7, 3'd7, mk(5, 7, 0));
    @(negedge clk);
    chk("flush_ready_low", bus.src_ready, 8'h00);
    step();
    flush = 1'b0;
    clear_all();
    @(negedge clk);
    chk("flush_valid_low", bus.cdb_valid, 0);
    chk("flush_ready_all", bus.src_ready, 8'hFF);
    step();
    p = cyc;
    expect_txn(1, 3'd1, mk(5, 1, 1), p + 2);
    expect_txn(5, 3'd5, mk(5, 5, 1), p + 3);
    drive(1, 3'd1, mk(5, 1, 1));
    drive(5, 3'd5, mk(5, 5, 1));
    step(); clear_all();
    repeat (5) step();

    // 6: reset mid-stream; buffered source 3 must never appear
    d = cyc;
    expect_txn(0, 3'd6, mk(6, 0, 0), d + 2);
    drive(0, 3'd6, mk(6, 0, 0));
    drive(3, 3'd3, mk(6, 3, 0));
    step(); clear_all();
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready_low", bus.src_ready, 8'h00);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", bus.cdb_valid, 0);
    chk("midrst_tag", bus.cdb_tag, 0);
    chk("midrst_data", bus.cdb_data, 0);
    chk("midrst_src", bus.cdb_src, 0);
    chk("midrst_ready_back", bus.src_ready, 8'hFF);
    repeat (4) step();
    p = cyc;
    expect_txn(3, 3'd7, mk(6, 3, 1), p + 2);
    drive(3, 3'd7, mk(6, 3, 1));
    step(); clear_all();
    repeat (4) step();

    @(negedge clk);
    chk("scoreboard_drained", 96'(sb.size()), 96'(0));
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
